// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoder, flag and memory-ready inputs plus the
// PC/IR/OR2 control strobes and status of the fetch/execute sequencer.
interface pc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             MEM_RDY;
    logic             TWO_BYTE;
    logic [1:0]       BR_TYPE;
    logic [1:0]       COND_SEL;
    logic             COND_NEG;
    logic             FLAG_Z;
    logic             FLAG_C;
    logic             FLAG_S;
    logic             HALT_OP;
    logic             RESUME;
    logic             I_PC;
    logic             L_PC;
    logic             S11;
    logic             S10;
    logic             L_IR;
    logic             L_OR2;
    logic             EX_EN;
    logic             HALTED;
    logic [2:0]       STATE;
    logic [CNT_W-1:0] RETIRED;

    modport master (
        input  MEM_RDY, TWO_BYTE, BR_TYPE, COND_SEL, COND_NEG,
        input  FLAG_Z, FLAG_C, FLAG_S, HALT_OP, RESUME,
        output I_PC, L_PC, S11, S10, L_IR, L_OR2, EX_EN,
        output HALTED, STATE, RETIRED
    );

    modport slave (
        output MEM_RDY, TWO_BYTE, BR_TYPE, COND_SEL, COND_NEG,
        output FLAG_Z, FLAG_C, FLAG_S, HALT_OP, RESUME,
        input  I_PC, L_PC, S11, S10, L_IR, L_OR2, EX_EN,
        input  HALTED, STATE, RETIRED
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch / operand / execute sequencer driving the PC,
// IR and OR2 load strobes of the 8-bit core; counts retired instructions.
module pc_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic          CLK,
    input  logic          RST,
    pc_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        OPERAND = 3'd2,
        EXEC    = 3'd3,
        BRWAIT  = 3'd4,
        HALT    = 3'd5
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       br_q;
    logic [1:0]       br_d;
    logic             two_q;
    logic             two_d;
    logic [CNT_W-1:0] retired_q;

    logic             i_pc;
    logic             l_pc;
    logic [1:0]       src;
    logic             l_ir;
    logic             l_or2;
    logic             ex_en;
    logic             retire;
    logic             cond_raw;
    logic             taken;

    // Branch resolution from the live flags and the latched branch kind.
    always_comb begin
        cond_raw = 1'b1;
        unique case (bus.COND_SEL)
            2'b00: cond_raw = 1'b1;
            2'b01: cond_raw = bus.FLAG_Z;
            2'b10: cond_raw = bus.FLAG_C;
            2'b11: cond_raw = bus.FLAG_S;
            default: cond_raw = 1'b1;
        endcase
        taken = (br_q != 2'b00) && (cond_raw ^ bus.COND_NEG);
    end

    // Next state, strobes and retire pulse for the current state.
    always_comb begin
        state_d = state_q;
        br_d    = br_q;
        two_d   = two_q;
        i_pc    = 1'b0;
        l_pc    = 1'b0;
        src     = 2'b00;
        l_ir    = 1'b0;
        l_or2   = 1'b0;
        ex_en   = 1'b0;
        retire  = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (bus.MEM_RDY) begin
                    l_ir    = 1'b1;
                    i_pc    = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                two_d = bus.TWO_BYTE;
                br_d  = bus.BR_TYPE;
                if (bus.HALT_OP) begin
                    state_d = HALT;
                    retire  = 1'b1;
                end else if (bus.TWO_BYTE) begin
                    state_d = OPERAND;
                end else begin
                    state_d = EXEC;
                end
            end
            OPERAND: begin
                if (bus.MEM_RDY) begin
                    l_or2   = two_q;
                    i_pc    = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                ex_en = 1'b1;
                if (!taken) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end else if (br_q == 2'b10) begin
                    state_d = BRWAIT;
                end else begin
                    l_pc    = 1'b1;
                    src     = br_q;
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            BRWAIT: begin
                if (bus.MEM_RDY) begin
                    l_pc    = 1'b1;
                    src     = 2'b10;
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            HALT: begin
                if (bus.RESUME) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State, latched decode fields and the retired counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= FETCH;
            br_q      <= 2'b00;
            two_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            br_q    <= br_d;
            two_q   <= two_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign bus.I_PC    = i_pc  & ~RST;
    assign bus.L_PC    = l_pc  & ~RST;
    assign bus.S11     = src[1] & ~RST;
    assign bus.S10     = src[0] & ~RST;
    assign bus.L_IR    = l_ir  & ~RST;
    assign bus.L_OR2   = l_or2 & ~RST;
    assign bus.EX_EN   = ex_en & ~RST;
    assign bus.HALTED  = (state_q == HALT);
    assign bus.STATE   = state_q;
    assign bus.RETIRED = retired_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: builds per-instruction expected cycle traces from the
// sequencing rules, replays their stimulus and compares every cycle.
module tb_pc_sequencer;
    localparam int CW  = 6;
    localparam int MOD = 1 << CW;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    pc_sequencer_if #(.CNT_W(CW)) b ();

    pc_sequencer #(.CNT_W(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (b)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit       rst, mem, two, halt, res, neg, fz, fc, fs;
        bit [1:0] br, csel;
        int       st;
        bit       i_pc, l_pc, l_ir, l_or2, ex_en;
        bit [1:0] s;
        int       ret;
    } rec_t;

    rec_t q[$];
    rec_t iq[$];
    int   m_ret  = 0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d want %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic rec_t blank(int st);
        rec_t r;
        r.rst = 0; r.mem = 1'($urandom); r.two = 1'($urandom);
        r.halt = 1'($urandom); r.res = 1'($urandom); r.neg = 1'($urandom);
        r.fz = 1'($urandom); r.fc = 1'($urandom); r.fs = 1'($urandom);
        r.br = 2'($urandom); r.csel = 2'($urandom);
        r.st = st; r.i_pc = 0; r.l_pc = 0; r.l_ir = 0; r.l_or2 = 0;
        r.ex_en = 0; r.s = 2'b00; r.ret = m_ret;
        return r;
    endfunction

    // rst_at: -1 none, -2 random cycle of this instruction, else that index
    task automatic gen_instr(bit two, bit [1:0] br, bit halt, bit [1:0] csel,
                             bit neg, bit fz, bit fc, bit fs, int wf, int wo,
                             int wb, int hc, int rst_at);
        rec_t r;
        bit   cv, taken;
        int   k, n;
        iq.delete();
        for (int i = 0; i < wf; i++) begin
            r = blank(0); r.mem = 0; iq.push_back(r);
        end
        r = blank(0); r.mem = 1; r.l_ir = 1; r.i_pc = 1; iq.push_back(r);
        r = blank(1); r.two = two; r.br = br; r.halt = halt; iq.push_back(r);
        if (halt) begin
            m_ret = (m_ret + 1) % MOD;
            for (int i = 0; i < hc; i++) begin
                r = blank(5); r.res = 0; iq.push_back(r);
            end
            r = blank(5); r.res = 1; iq.push_back(r);
        end else begin
            if (two) begin
                for (int i = 0; i < wo; i++) begin
                    r = blank(2); r.mem = 0; iq.push_back(r);
                end
                r = blank(2); r.mem = 1; r.l_or2 = 1; r.i_pc = 1;
                iq.push_back(r);
            end
            r = blank(3); r.csel = csel; r.neg = neg;
            r.fz = fz; r.fc = fc; r.fs = fs; r.ex_en = 1;
            cv = (csel == 0) ? 1'b1 : (csel == 1) ? fz : (csel == 2) ? fc : fs;
            taken = (br != 0) && (cv ^ neg);
            if (taken && br != 2) begin
                r.l_pc = 1; r.s = br;
            end
            iq.push_back(r);
            if (taken && br == 2) begin
                for (int i = 0; i < wb; i++) begin
                    r = blank(4); r.mem = 0; iq.push_back(r);
                end
                r = blank(4); r.mem = 1; r.l_pc = 1; r.s = 2'b10;
                iq.push_back(r);
            end
            m_ret = (m_ret + 1) % MOD;
        end
        k = (rst_at == -2) ? int'($urandom_range(iq.size() - 1)) : rst_at;
        if (k >= 0 && k < iq.size()) begin
            for (int i = 0; i < k; i++) q.push_back(iq[i]);
            r = iq[k];
            r.rst = 1; r.i_pc = 0; r.l_pc = 0; r.l_ir = 0; r.l_or2 = 0;
            r.ex_en = 0; r.s = 2'b00;
            q.push_back(r);
            m_ret = 0;
            n = 1 + int'($urandom_range(1));
            for (int i = 0; i < n; i++) begin
                r = blank(0); r.rst = 1; q.push_back(r);
            end
        end else begin
            foreach (iq[i]) q.push_back(iq[i]);
        end
    endtask

    task automatic simple(int n);
        for (int i = 0; i < n; i++)
            gen_instr(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic compare(rec_t r);
        chk("state", int'(b.STATE), r.st);
        chk("strobes",
            int'({b.I_PC, b.L_PC, b.S11, b.S10, b.L_IR, b.L_OR2, b.EX_EN}),
            int'({r.i_pc, r.l_pc, r.s, r.l_ir, r.l_or2, r.ex_en}));
        chk("halted", int'(b.HALTED), int'(r.st == 5));
        chk("retired", int'(b.RETIRED), r.ret);
        chk("lpc_ipc_excl", int'(b.L_PC & b.I_PC), 0);
        chk("src_idle", int'(!b.L_PC && (b.S11 || b.S10)), 0);
        chk("load_onehot", int'($countones({b.L_IR, b.L_OR2, b.L_PC}) > 1), 0);
    endtask

    task automatic run_q();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            RST        = r.rst;
            b.MEM_RDY  = r.mem;  b.TWO_BYTE = r.two; b.BR_TYPE = r.br;
            b.COND_SEL = r.csel; b.COND_NEG = r.neg; b.HALT_OP = r.halt;
            b.RESUME   = r.res;  b.FLAG_Z = r.fz; b.FLAG_C = r.fc;
            b.FLAG_S   = r.fs;
            @(negedge CLK);
            compare(r);
            @(posedge CLK);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int wf, wo, wb;
        b.MEM_RDY = 0; b.TWO_BYTE = 0; b.BR_TYPE = 0; b.COND_SEL = 0;
        b.COND_NEG = 0; b.HALT_OP = 0; b.RESUME = 0;
        b.FLAG_Z = 0; b.FLAG_C = 0; b.FLAG_S = 0;
        RST = 1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_state", int'(b.STATE), 0);
        chk("reset_retired", int'(b.RETIRED), 0);
        chk("reset_strobes", int'({b.I_PC, b.L_PC, b.L_IR, b.L_OR2, b.EX_EN}), 0);
        @(posedge CLK);
        #1;

        simple(3);
        chk("pin_len3", q.size(), 9);
        chk("pin_ipc0", int'(q[0].i_pc && q[0].l_ir), 1);
        chk("pin_ipc3", int'(q[3].i_pc && q[3].l_ir), 1);
        chk("pin_ipc6", int'(q[6].i_pc && q[6].l_ir), 1);
        run_q();
        chk("retired_after3", int'(b.RETIRED), 3);

        gen_instr(1, 2'b01, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        chk("pin_or2", int'(q[2].l_or2 && q[2].i_pc), 1);
        chk("pin_jmp_or2", int'(q[3].l_pc) * 4 + int'(q[3].s), 5);
        gen_instr(0, 2'b11, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        gen_instr(0, 2'b11, 0, 2'b01, 0, 1, 0, 0, 0, 0, 0, 0, -1);
        gen_instr(0, 2'b11, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0, -1);
        gen_instr(0, 2'b01, 0, 2'b00, 1, 1, 1, 1, 0, 0, 0, 0, -1);
        gen_instr(0, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 0, -1);
        chk("pin_brwait_end", int'(q[$].st == 4 && q[$].l_pc && q[$].s == 2), 1);
        gen_instr(0, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 10, -1);
        run_q();
        chk("retired_after_dir", int'(b.RETIRED), 10);

        gen_instr(1, 2'b01, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        run_q();
        chk("retired_after_rst", int'(b.RETIRED), 0);
        chk("state_after_rst", int'(b.STATE), 0);

        simple(MOD + 2);
        run_q();
        chk("retired_wrap", int'(b.RETIRED), 2);

        for (int n = 0; n < 350; n++) begin
            wf = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0;
            wo = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0;
            wb = ($urandom_range(3) == 0) ? int'($urandom_range(4)) : 0;
            gen_instr(1'($urandom), 2'($urandom), ($urandom_range(9) == 0),
                      2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), wf, wo, wb, int'($urandom_range(4)),
                      ($urandom_range(15) == 0) ? -2 : -1);
            run_q();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/execute sequencer that owns the program counter's control inputs: increment, load, and the 2-bit PC source select.
- Walks each instruction through fetch, optional operand fetch and execute.
- Resolves jumps, conditional or unconditional, from operand register 2 (OR2), from data memory or from R0.
- Also strobes the instruction register (IR) and OR2 loads and counts retired instructions.
- Sits between the instruction decoder and the PC, IR and OR2 registers of the 8-bit core.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  synchronous reset, active-high.
- MEM_RDY  in  1  memory read data valid this cycle.
- TWO_BYTE  in  1  decoded instruction carries an operand byte; sampled in DECODE.
- BR_TYPE  in  2  branch kind: 00 none, 01 target from OR2, 10 target from data memory, 11 target from R0; sampled in DECODE.
- COND_SEL  in  2  branch condition: 00 always, 01 Z, 10 C, 11 S.
- COND_NEG  in  1  invert the selected condition.
- FLAG_Z, FLAG_C, FLAG_S  in  1 each  ALU flags; sampled in EXEC.
- HALT_OP  in  1  decoded halt instruction.
- RESUME  in  1  leave HALT.
- I_PC  out  1  PC increment strobe.
- L_PC  out  1  PC load strobe.
- S11, S10  out  1 each  PC source select: 01 OR2, 10 data memory, 11 R0.
- L_IR  out  1  IR load strobe.
- L_OR2  out  1  OR2 load strobe.
- EX_EN  out  1  one-cycle execute enable to the datapath.
- HALTED  out  1  high while in HALT.
- STATE  out  3  current state encoding, for debug.
- RETIRED  out  CNT_W  retired-instruction count.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, OPERAND=2, EXEC=3, BRWAIT=4, HALT=5.
- Reset:
  - RST high at a clock edge forces state FETCH and RETIRED=0.
  - All strobes are Moore/Mealy-registered-free combinational outputs of state and inputs, so while RST is high they read 0.
  - Reset mid-instruction abandons the instruction with no PC action and does not retire it.
- FETCH:
  - Wait while MEM_RDY=0 (all strobes 0).
  - When MEM_RDY=1: L_IR=1, I_PC=1, next state DECODE.
- DECODE:
  - HALT_OP=1 → HALT. The halt retires on entry, so RETIRED+1.
  - Otherwise TWO_BYTE=1 → OPERAND, else → EXEC.
  - TWO_BYTE and BR_TYPE are latched internally on this edge.
  - No strobes are asserted in DECODE.
- OPERAND:
  - Wait on MEM_RDY.
  - When MEM_RDY=1: L_OR2=1, I_PC=1, next state EXEC.
- EXEC:
  - EX_EN=1 for exactly one cycle.
  - taken = BR_TYPE≠00 AND (COND_SEL==00 ? 1 : selected flag) XOR COND_NEG.
  - COND_NEG with COND_SEL=00 yields never-taken.
  - Not taken: next state FETCH, RETIRED+1.
  - Taken with BR_TYPE 01 or 11: L_PC=1 with {S11,S10}=BR_TYPE, next state FETCH, RETIRED+1.
  - Taken with BR_TYPE 10: next state BRWAIT, no PC strobe yet.
- BRWAIT:
  - Wait on MEM_RDY.
  - When MEM_RDY=1: L_PC=1, {S11,S10}=10, next state FETCH, RETIRED+1.
- HALT:
  - HALTED=1; hold here.
  - RESUME=1 → FETCH on the next edge, PC untouched (points after the halt).
- Invariants:
  - L_PC and I_PC are never high in the same cycle.
  - {S11,S10}=00 whenever L_PC=0.
  - At most one of L_IR, L_OR2, L_PC is high per cycle.
- RETIRED wraps from all-ones to 0.
- Latency, zero-wait memory:
  - 1-byte instruction: 3 cycles.
  - 2-byte instruction: 4 cycles.
  - Memory-indirect taken jump: 5 cycles.

Test Plan:
- Reset, release, MEM_RDY=1, three 1-byte non-branch instructions → I_PC pulses in cycles 0, 3 and 6 with L_IR in the same cycles; RETIRED=3 after 9 cycles; L_PC never high.
- 2-byte instruction, BR_TYPE=01, COND_SEL=00 → I_PC in FETCH and in OPERAND, L_OR2 in OPERAND, then L_PC=1 with S11,S10=01 in EXEC; back to FETCH.
- BR_TYPE=11, COND_SEL=01, FLAG_Z=0 → no L_PC, next state FETCH. Repeat with FLAG_Z=1 → L_PC=1, S=11. Repeat with FLAG_Z=1 and COND_NEG=1 → no L_PC.
- BR_TYPE=10 taken, MEM_RDY held low 4 cycles in BRWAIT → state stays 4 and all strobes stay 0; on MEM_RDY=1, a single L_PC pulse with S=10.
- HALT_OP in DECODE → HALTED=1 and STATE=5 held for 10 cycles with RESUME=0; RESUME=1 → FETCH next cycle with no PC strobe.
- RST asserted during OPERAND → next cycle STATE=0 and RETIRED=0, no L_OR2 or I_PC; RETIRED preloaded near 2^CNT_W−1 wraps to 0.
